// File: rtl/clock_reset_pkg.sv
// Shared definitions for the post-PLL clock/reset supervisor:
// FSM state encoding and the sizing helper for the shared cycle counter.
package clock_reset_pkg;

    localparam logic [1:0] ST_WAIT_LOCK  = 2'd0;
    localparam logic [1:0] ST_STABILISE  = 2'd1;
    localparam logic [1:0] ST_HOLD_RESET = 2'd2;
    localparam logic [1:0] ST_RUN        = 2'd3;

    typedef enum logic [1:0] {
        WAIT_LOCK  = ST_WAIT_LOCK,
        STABILISE  = ST_STABILISE,
        HOLD_RESET = ST_HOLD_RESET,
        RUN        = ST_RUN
    } state_t;

    // Counter must reach max(stable, hold) - 1; never narrower than one bit.
    function automatic int cycle_count_width(input int stable_cycles, input int hold_cycles);
        int longest;
        longest = (stable_cycles > hold_cycles) ? stable_cycles : hold_cycles;
        return (longest <= 1) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// One clock-enable generator: counts 0..divide-1 while run is high and
// emits a registered strobe in the cycle the count equals divide-1.
module tick_divider #(
    parameter int DIV_WIDTH = 20
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] divide,
    output logic                 tick
);

    logic                 active_reg;
    logic [DIV_WIDTH-1:0] count_reg;
    logic [DIV_WIDTH-1:0] count_next;
    logic                 tick_reg;
    logic                 tick_next;
    logic [DIV_WIDTH-1:0] last;

    assign last = divide - 1'b1;

    // run is the supervisor's next-state view, so the entry edge leaves the
    // count at 0 and the exit edge clears it together with the state change.
    always_comb begin
        count_next = '0;
        if (run && active_reg) begin
            count_next = (count_reg == last) ? '0 : count_reg + 1'b1;
        end
        tick_next = run && (count_next == last);
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            active_reg <= 1'b0;
            count_reg  <= '0;
            tick_reg   <= 1'b0;
        end else begin
            active_reg <= run;
            count_reg  <= count_next;
            tick_reg   <= tick_next;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/clock_reset_manager.sv
// Post-PLL supervisor: synchronises lock, sequences reset release, generates
// clock-enable strobes while running and counts lock losses from RUN.
module clock_reset_manager
    import clock_reset_pkg::*;
#(
    parameter int                                 NUM_ENABLES       = 2,
    parameter int                                 DIV_WIDTH         = 20,
    parameter logic [NUM_ENABLES*DIV_WIDTH-1:0]   DIVIDERS          = {20'd96000, 20'd96},
    parameter int                                 STABLE_CYCLES     = 1024,
    parameter int                                 RESET_HOLD_CYCLES = 16,
    parameter int                                 COUNT_WIDTH       = 8
) (
    input  logic                   clock_in,
    input  logic                   reset,
    input  logic                   pll_locked,
    output logic                   reset_out,
    output logic                   ready,
    output logic [NUM_ENABLES-1:0] enable,
    output logic [COUNT_WIDTH-1:0] lock_loss_count
);

    localparam int            CW          = cycle_count_width(STABLE_CYCLES, RESET_HOLD_CYCLES);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(RESET_HOLD_CYCLES - 1);

    if (NUM_ENABLES < 1 || NUM_ENABLES > 8) begin : g_bad_num_enables
        $fatal(1, "clock_reset_manager: NUM_ENABLES must be 1..8");
    end

    logic [1:0]             sync_reg;
    logic                   locked_sync;
    state_t                 state_reg;
    state_t                 state_next;
    logic [CW-1:0]          count_reg;
    logic [CW-1:0]          count_next;
    logic                   loss_event;
    logic [COUNT_WIDTH-1:0] loss_count_reg;
    logic                   reset_out_reg;
    logic                   ready_reg;
    logic                   run_next;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], pll_locked};
        end
    end

    assign locked_sync = sync_reg[1];

    always_comb begin
        state_next = state_reg;
        count_next = count_reg + 1'b1;
        loss_event = 1'b0;
        case (state_reg)
            WAIT_LOCK: begin
                count_next = '0;
                if (locked_sync) begin
                    state_next = STABILISE;
                end
            end
            STABILISE: begin
                if (!locked_sync) begin
                    state_next = WAIT_LOCK;
                end else if (count_reg == STABLE_LAST) begin
                    state_next = HOLD_RESET;
                end
            end
            HOLD_RESET: begin
                if (!locked_sync) begin
                    state_next = WAIT_LOCK;
                end else if (count_reg == HOLD_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                count_next = '0;
                if (!locked_sync) begin
                    state_next = WAIT_LOCK;
                    loss_event = 1'b1;
                end
            end
            default: begin
                state_next = WAIT_LOCK;
            end
        endcase
        // Any transition restarts timing; partial counts are never kept.
        if (state_next != state_reg) begin
            count_next = '0;
        end
    end

    assign run_next = (state_next == RUN);

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_reg      <= WAIT_LOCK;
            count_reg      <= '0;
            loss_count_reg <= '0;
            reset_out_reg  <= 1'b1;
            ready_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            reset_out_reg <= !run_next;
            ready_reg     <= run_next;
            if (loss_event && (loss_count_reg != {COUNT_WIDTH{1'b1}})) begin
                loss_count_reg <= loss_count_reg + 1'b1;
            end
        end
    end

    assign reset_out       = reset_out_reg;
    assign ready           = ready_reg;
    assign lock_loss_count = loss_count_reg;

    for (genvar gi = 0; gi < NUM_ENABLES; gi++) begin : g_div
        localparam logic [DIV_WIDTH-1:0] DIV_I = DIVIDERS[gi*DIV_WIDTH +: DIV_WIDTH];

        if (DIV_I == '0) begin : g_bad_divider
            $fatal(1, "clock_reset_manager: DIVIDERS entries must be >= 1");
        end

        tick_divider #(
            .DIV_WIDTH (DIV_WIDTH)
        ) u_tick_divider (
            .clock_in (clock_in),
            .reset    (reset),
            .run      (run_next),
            .divide   (DIV_I),
            .tick     (enable[gi])
        );
    end

endmodule

// File: tb/tb_clock_reset_manager.sv
// Directed bench: release timing, strobe cadence, lock drops, saturation
// and asynchronous reset, with hand-computed expectations.
module tb_clock_reset_manager;

    logic       clk;
    logic       rst;
    logic       pll;
    logic       reset_out;
    logic       ready;
    logic [1:0] enable;
    logic [1:0] loss_count;

    int tests_run = 0;
    int failed    = 0;

    // Entry 0 divides by 5, entry 1 by 1 (continuous strobe in RUN).
    clock_reset_manager #(
        .NUM_ENABLES       (2),
        .DIV_WIDTH         (20),
        .DIVIDERS          ({20'd1, 20'd5}),
        .STABLE_CYCLES     (8),
        .RESET_HOLD_CYCLES (4),
        .COUNT_WIDTH       (2)
    ) dut (
        .clock_in        (clk),
        .reset           (rst),
        .pll_locked      (pll),
        .reset_out       (reset_out),
        .ready           (ready),
        .enable          (enable),
        .lock_loss_count (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge: the next edge samples lock high
    // (edge 0), so release must land exactly on edge 14 (2 + 8 + 4).
    task automatic release_seq(input string tag);
        pll = 1'b1;
        edges(14);
        chk({tag, "_rst_e13"}, 32'(reset_out), 32'd1);
        chk({tag, "_en_e13"}, 32'(enable), 32'd0);
        edges(1);
        chk({tag, "_rst_e14"}, 32'(reset_out), 32'd0);
        chk({tag, "_rdy_e14"}, 32'(ready), 32'd1);
        chk({tag, "_en_e14"}, 32'(enable), 32'b10);
    endtask

    // Run cycles after entry: enable[0] in cycles 4, 9, 14; enable[1] always.
    task automatic cadence(input string tag, input int cycles);
        for (int j = 1; j <= cycles; j++) begin
            edges(1);
            chk($sformatf("%s_cyc%0d", tag, j), 32'(enable), {30'd0, 1'b1, (j % 5) == 4});
        end
    endtask

    initial begin
        rst = 1'b0;
        pll = 1'b0;
        #1 rst = 1'b1;
        edges(2);
        chk("reset_rst_out", 32'(reset_out), 32'd1);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_enable", 32'(enable), 32'd0);
        chk("reset_count", 32'(loss_count), 32'd0);
        rst = 1'b0;
        edges(3);
        chk("nolock_rst_out", 32'(reset_out), 32'd1);

        release_seq("clean");
        cadence("cad", 14);

        // Async reset between edges: outputs must change before any edge.
        #3 rst = 1'b1;
        #1;
        chk("arst_rst_out", 32'(reset_out), 32'd1);
        chk("arst_ready", 32'(ready), 32'd0);
        chk("arst_enable", 32'(enable), 32'd0);
        chk("arst_count", 32'(loss_count), 32'd0);
        pll = 1'b0;
        edges(2);
        rst = 1'b0;
        edges(2);

        // Lock at edge 0, drop sampled at edges 5..7, relock sampled at edge 8.
        pll = 1'b1;
        edges(5);
        pll = 1'b0;
        edges(3);
        chk("stab_drop_rst", 32'(reset_out), 32'd1);
        release_seq("relock_stab");
        chk("stab_drop_count", 32'(loss_count), 32'd0);
        cadence("cad2", 5);

        // Drop in RUN sampled at edge k: still running at k+1, out at k+2.
        pll = 1'b0;
        edges(2);
        chk("drop_k1_rst", 32'(reset_out), 32'd0);
        chk("drop_k1_count", 32'(loss_count), 32'd0);
        edges(1);
        chk("drop_k2_rst", 32'(reset_out), 32'd1);
        chk("drop_k2_ready", 32'(ready), 32'd0);
        chk("drop_k2_enable", 32'(enable), 32'd0);
        chk("drop_k2_count", 32'(loss_count), 32'd1);
        edges(3);
        release_seq("relock_run");
        cadence("cad3", 5);

        // Two-bit counter: 2, 3, then stays at 3.
        for (int n = 2; n <= 4; n++) begin
            pll = 1'b0;
            edges(3);
            chk($sformatf("sat_loss%0d", n), 32'(loss_count), (n > 3) ? 32'd3 : 32'(n));
            chk($sformatf("sat_rst%0d", n), 32'(reset_out), 32'd1);
            edges(2);
            release_seq($sformatf("sat_relock%0d", n));
        end

        edges(2);
        #3 rst = 1'b1;
        #1;
        chk("arst2_count", 32'(loss_count), 32'd0);
        chk("arst2_rst_out", 32'(reset_out), 32'd1);
        chk("arst2_enable", 32'(enable), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
